// File: rtl/psum_tile_issuer.sv
// MAC-side partial-sum tile issuer: accumulates K beats per tile into a
// two-entry ping-pong buffer and presents completed tiles to the ppu.
module psum_tile_issuer #(
    parameter int LANES  = 16,
    parameter int PSUM_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mac_valid,
    output logic                      mac_ready,
    input  logic [LANES*PSUM_W-1:0]   mac_psum,
    input  logic                      mac_last,
    input  logic [7:0]                tile_scale,
    input  logic [7:0]                tile_bias,
    output logic                      ppu_valid,
    output logic [LANES*PSUM_W-1:0]   ppu_partial_sum,
    output logic [7:0]                ppu_scale,
    output logic [7:0]                ppu_bias,
    input  logic                      ppu_done,
    output logic                      overflow,
    output logic [CNT_W-1:0]          tile_count
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state;

    logic [PSUM_W-1:0] acc [2][LANES];
    logic [7:0]        ent_scale [2];
    logic [7:0]        ent_bias [2];
    logic [1:0]        full;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              mid_tile;
    logic              beat;

    logic [PSUM_W-1:0] base [LANES];
    logic [PSUM_W:0]   wide [LANES];
    logic [PSUM_W-1:0] nxt_sum [LANES];
    logic [LANES-1:0]  sat;
    logic [LANES*PSUM_W-1:0] rd_sum;

    assign mac_ready = !full[wr_ptr];
    assign beat      = mac_valid && mac_ready;

    // First beat of a tile loads, later beats add with saturation.
    always_comb begin
        sat = '0;
        for (int i = 0; i < LANES; i++) begin
            base[i]    = mid_tile ? acc[wr_ptr][i] : '0;
            wide[i]    = {1'b0, base[i]}
                       + {1'b0, mac_psum[i*PSUM_W +: PSUM_W]};
            sat[i]     = wide[i][PSUM_W];
            nxt_sum[i] = sat[i] ? '1 : wide[i][PSUM_W-1:0];
        end
    end

    always_comb begin
        rd_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_sum[i*PSUM_W +: PSUM_W] = acc[rd_ptr][i];
        end
    end

    // Buffer storage needs no reset: full/mid_tile gate every use.
    always_ff @(posedge clk) begin
        if (beat) begin
            for (int i = 0; i < LANES; i++) begin
                acc[wr_ptr][i] <= nxt_sum[i];
            end
            if (mac_last) begin
                ent_scale[wr_ptr] <= tile_scale;
                ent_bias[wr_ptr]  <= tile_bias;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            full            <= '0;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            mid_tile        <= 1'b0;
            overflow        <= 1'b0;
            tile_count      <= '0;
            ppu_valid       <= 1'b0;
            ppu_partial_sum <= '0;
            ppu_scale       <= '0;
            ppu_bias        <= '0;
        end else begin
            if (beat) begin
                mid_tile <= !mac_last;
                if (|sat) begin
                    overflow <= 1'b1;
                end
                if (mac_last) begin
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= !wr_ptr;
                end
            end
            case (state)
                IDLE: begin
                    if (full[rd_ptr]) begin
                        state           <= ISSUE;
                        ppu_valid       <= 1'b1;
                        ppu_partial_sum <= rd_sum;
                        ppu_scale       <= ent_scale[rd_ptr];
                        ppu_bias        <= ent_bias[rd_ptr];
                    end
                end
                ISSUE: begin
                    // Retire never hits the entry being written this edge.
                    if (ppu_done) begin
                        state           <= IDLE;
                        ppu_valid       <= 1'b0;
                        ppu_partial_sum <= '0;
                        ppu_scale       <= '0;
                        ppu_bias        <= '0;
                        full[rd_ptr]    <= 1'b0;
                        rd_ptr          <= !rd_ptr;
                        tile_count      <= tile_count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
